gain_stage: RTL

- Pipelined signed gain stage directly downstream of the derivative cell. Also usable after integrator/proportional cells.
- Multiplies each valid sample by a programmable signed fixed-point coefficient (e.g. Kd), shifts out fractional bits, saturates to the data width and emits a one-cycle valid.
- Output drops straight into the PID summing stage.

---
 rtl/cell_pkg.sv | 32 +++
 rtl/gain_stage_if.sv | 38 +++
 rtl/gain_stage_sat_clip.sv | 41 ++++
 rtl/gain_stage.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/cell_pkg.sv
// -----------------------------------------------------------------------------
// cell_pkg
// Shared definitions for the controller cell chain (derivative, integrator,
// proportional, gain and summing cells).
//   - default data / coefficient / fraction widths
//   - signed saturation limits for an arbitrary width
//   - sample_t: value + valid pair used on links between cells
// No ports (package).
// -----------------------------------------------------------------------------
package cell_pkg;

   localparam int CELL_DATA_W = 32;
   localparam int CELL_COEF_W = 16;
   localparam int CELL_FRAC   = 8;

   // Largest representable value of a w-bit two's-complement number (w <= 64).
   function automatic logic signed [63:0] sat_max_f(input int w);
      return (64'sd1 <<< (w - 1)) - 64'sd1;
   endfunction

   // Smallest representable value of a w-bit two's-complement number (w <= 64).
   function automatic logic signed [63:0] sat_min_f(input int w);
      return -(64'sd1 <<< (w - 1));
   endfunction

   // One sample on a cell-to-cell link at the default data width.
   typedef struct packed {
      logic                          valid;
      logic signed [CELL_DATA_W-1:0] value;
   } sample_t;

endpackage

// File: rtl/gain_stage_if.sv
// -----------------------------------------------------------------------------
// gain_stage_if
// Sample / coefficient bus of the gain stage.
//   data_in, data_en        : incoming sample and its valid strobe
//   coef_in, coef_wr        : coefficient write into the shadow register
//   coef_pending            : shadow written, not yet applied
//   data_out, data_en_out   : scaled, saturated result and its valid pulse
//   sat_out                 : result was clipped (qualified by data_en_out)
// Handshake: valid-only, no ready. A strobe (data_en, coef_wr, data_en_out)
// is one transfer per clock in which it is sampled high; the receiver must
// always accept, there is no back-pressure and no stall.
// Modports: master = sample/coefficient source, slave = gain stage.
// -----------------------------------------------------------------------------
interface gain_stage_if #(
   parameter int MSB    = 31,
   parameter int COEF_W = 16
);

   logic signed [MSB:0]      data_in;
   logic                     data_en;
   logic signed [COEF_W-1:0] coef_in;
   logic                     coef_wr;
   logic                     coef_pending;
   logic signed [MSB:0]      data_out;
   logic                     data_en_out;
   logic                     sat_out;

   modport master (
      output data_in, data_en, coef_in, coef_wr,
      input  coef_pending, data_out, data_en_out, sat_out
   );

   modport slave (
      input  data_in, data_en, coef_in, coef_wr,
      output coef_pending, data_out, data_en_out, sat_out
   );

endinterface

// File: rtl/gain_stage_sat_clip.sv
// -----------------------------------------------------------------------------
// sat_clip
// Combinational signed clip from IN_W bits down to OUT_W bits (IN_W > OUT_W).
// Ports:
//   i_val  in  IN_W   signed value to clip
//   o_val  out OUT_W  value clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
//   o_sat  out 1      high when clamping changed the value
// Reusable by any cell that narrows a wide intermediate result.
// -----------------------------------------------------------------------------
module sat_clip
   import cell_pkg::*;
#(
   parameter int IN_W  = 48,
   parameter int OUT_W = 32
) (
   input  logic signed [IN_W-1:0]  i_val,
   output logic signed [OUT_W-1:0] o_val,
   output logic                    o_sat
);

   localparam logic signed [OUT_W-1:0] MAX_V = OUT_W'(sat_max_f(OUT_W));
   localparam logic signed [OUT_W-1:0] MIN_V = OUT_W'(sat_min_f(OUT_W));

   // The value fits when every bit from the output sign bit upward is a copy
   // of the input sign bit.
   logic [IN_W-OUT_W:0] w_top;
   logic                w_fits;

   assign w_top  = i_val[IN_W-1:OUT_W-1];
   assign w_fits = (&w_top) | ~(|w_top);

   always_comb begin
      o_sat = 1'b0;
      o_val = i_val[OUT_W-1:0];
      if (!w_fits) begin
         o_sat = 1'b1;
         o_val = i_val[IN_W-1] ? MIN_V : MAX_V;
      end
   end

endmodule

// File: rtl/gain_stage.sv
// -----------------------------------------------------------------------------
// gain_stage
// Pipelined signed gain: data_out = sat(data_in * coef >>> FRAC).
// Three register stages: S1 multiply, S2 (round +) shift, S3 clip.
// A sample accepted on edge N is presented with data_en_out after edge N+2,
// i.e. it is sampled high on edge N+3.
// Ports:
//   clk  in  clock
//   rst  in  asynchronous, active-high reset
//   bus  slave modport of gain_stage_if (sample in, coefficient write,
//        result out, saturation flag, coefficient pending)
// Build option: GAIN_STAGE_ROUND_EN adds 2^(FRAC-1) before the shift
// (round half toward +inf); without it the shift truncates toward -inf.
// Coefficient update: coef_wr loads a shadow register. The clock after any
// accepted sample, a pending shadow becomes the active coefficient; the
// sample accepted in that same clock already sees the new value.
// -----------------------------------------------------------------------------
module gain_stage
   import cell_pkg::*;
#(
   parameter int MSB        = CELL_DATA_W - 1,
   parameter int COEF_W     = CELL_COEF_W,
   parameter int FRAC       = CELL_FRAC,
   parameter int RESET_COEF = 1 << FRAC
) (
   input  logic   clk,
   input  logic   rst,
   gain_stage_if.slave bus
);

   localparam int W  = MSB + 1;
   localparam int PW = W + COEF_W;   // full product width
   localparam int EW = PW + 1;       // headroom for the rounding add

`ifdef GAIN_STAGE_ROUND_EN
   localparam logic signed [EW-1:0] RND_ADD =
      (FRAC > 0) ? (EW'(1) << ((FRAC > 0) ? (FRAC - 1) : 0)) : '0;
`else
   localparam logic signed [EW-1:0] RND_ADD = '0;
`endif

   // ---------------- coefficient registers ----------------
   logic signed [COEF_W-1:0] r_coef_active;
   logic signed [COEF_W-1:0] r_coef_shadow;
   logic                     r_coef_pending;
   logic                     r_acc_d;       // a sample was accepted last clock
   logic                     w_xfer;
   logic signed [COEF_W-1:0] w_coef_eff;

   // Transfer happens in the clock after an acceptance; the sample arriving in
   // that clock must already use the new value, hence the bypass mux.
   assign w_xfer     = r_coef_pending & r_acc_d;
   assign w_coef_eff = w_xfer ? r_coef_shadow : r_coef_active;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_coef_active  <= COEF_W'(RESET_COEF);
         r_coef_shadow  <= '0;
         r_coef_pending <= 1'b0;
         r_acc_d        <= 1'b0;
      end else begin
         r_acc_d <= bus.data_en;
         if (w_xfer) begin
            r_coef_active <= r_coef_shadow;
         end
         // A write coinciding with a transfer reloads the shadow after the old
         // shadow has moved, so pending stays set.
         if (bus.coef_wr) begin
            r_coef_shadow  <= bus.coef_in;
            r_coef_pending <= 1'b1;
         end else if (w_xfer) begin
            r_coef_pending <= 1'b0;
         end
      end
   end

   // ---------------- S1: multiply ----------------
   logic signed [PW-1:0] w_din_x;
   logic signed [PW-1:0] w_coef_x;
   logic signed [PW-1:0] w_prod;
   logic signed [PW-1:0] r_s1_prod;
   logic                 r_s1_valid;

   assign w_din_x  = {{COEF_W{bus.data_in[MSB]}}, bus.data_in};
   assign w_coef_x = {{W{w_coef_eff[COEF_W-1]}}, w_coef_eff};
   assign w_prod   = w_din_x * w_coef_x;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_prod  <= '0;
      end else begin
         r_s1_valid <= bus.data_en;
         if (bus.data_en) begin
            r_s1_prod <= w_prod;
         end
      end
   end

   // ---------------- S2: round / shift ----------------
   logic signed [EW-1:0] w_s2_ext;
   logic signed [EW-1:0] w_s2_sum;
   logic signed [EW-1:0] w_s2_shift;
   logic signed [EW-1:0] r_s2_val;
   logic                 r_s2_valid;

   assign w_s2_ext   = {r_s1_prod[PW-1], r_s1_prod};
   assign w_s2_sum   = w_s2_ext + RND_ADD;
   assign w_s2_shift = w_s2_sum >>> FRAC;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_val   <= '0;
      end else begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_val <= w_s2_shift;
         end
      end
   end

   // ---------------- S3: clip ----------------
   logic signed [W-1:0] w_clip_val;
   logic                w_clip_sat;
   logic signed [W-1:0] r_data_out;
   logic                r_sat_out;
   logic                r_s3_valid;

   sat_clip #(
      .IN_W  (EW),
      .OUT_W (W)
   ) u_sat_clip (
      .i_val (r_s2_val),
      .o_val (w_clip_val),
      .o_sat (w_clip_sat)
   );

   // data_out / sat_out hold their last result while no sample completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s3_valid <= 1'b0;
         r_data_out <= '0;
         r_sat_out  <= 1'b0;
      end else begin
         r_s3_valid <= r_s2_valid;
         if (r_s2_valid) begin
            r_data_out <= w_clip_val;
            r_sat_out  <= w_clip_sat;
         end
      end
   end

   assign bus.data_out     = r_data_out;
   assign bus.sat_out      = r_sat_out;
   assign bus.data_en_out  = r_s3_valid;
   assign bus.coef_pending = r_coef_pending;

endmodule
